// File: rtl/sgpio_pkg.sv
// Shared types, defaults and sizing helpers for the SGPIO debug serializer.
package sgpio_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned HALF_DIV_DEF = 250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRST  = 2'd1,
        ST_SHIFT = 2'd2
    } sgpio_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sgpio_shifter_if.sv
// Request side (en/data/strobe) plus the 3-wire SGPIO debug link.
interface sgpio_shifter_if #(
    parameter int unsigned DATA_W = sgpio_pkg::DATA_W_DEF
);
    logic              en;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              SGPIO_FPGA_DBG_CPU0_DATA;
    logic              SGPIO_FPGA_DBG_RST_N;
    logic              SGPIO_FPGA_DBG_CLK_100k;

    modport master (
        output en, i_data, i_valid,
        input  SGPIO_FPGA_DBG_CPU0_DATA, SGPIO_FPGA_DBG_RST_N, SGPIO_FPGA_DBG_CLK_100k
    );

    modport slave (
        input  en, i_data, i_valid,
        output SGPIO_FPGA_DBG_CPU0_DATA, SGPIO_FPGA_DBG_RST_N, SGPIO_FPGA_DBG_CLK_100k
    );
endinterface

// File: rtl/sgpio_tick_gen.sv
// Half-period timebase: phase_tick_o pulses once every HALF_DIV cycles while enabled.
module sgpio_tick_gen
    import sgpio_pkg::*;
#(
    parameter int unsigned HALF_DIV = HALF_DIV_DEF  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic phase_tick_o
);

    localparam int unsigned   CW       = cnt_w(HALF_DIV);
    localparam logic [CW-1:0] WRAP     = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] PRE_WRAP = CW'(HALF_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Tick is registered one count early so it is high exactly while cnt_q == WRAP.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d  = (cnt_q == WRAP) ? '0 : cnt_q + CW'(1);
            tick_d = (cnt_q == PRE_WRAP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign phase_tick_o = tick_q;

endmodule

// File: rtl/sgpio_shifter.sv
// Serializes one byte per accepted strobe onto the SGPIO link: frame reset, then MSB-first bits.
module sgpio_shifter
    import sgpio_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,   // must be >= 2
    parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            reset,
    sgpio_shifter_if.slave  bus
);

    localparam int unsigned BW = cnt_w(DATA_W);

    sgpio_state_e      state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              phase_q, phase_d;
    logic              data_q, data_d;
    logic              sclk_q, sclk_d;
    logic              frst_n_q, frst_n_d;
    logic              tick;

    sgpio_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk          (aclk),
        .rst_n        (aresetn),
        .clr_i        (reset || (state_q == ST_IDLE)),
        .en_i         (state_q != ST_IDLE),
        .phase_tick_o (tick)
    );

    // phase_q marks the second half-period of the frame reset or of the current bit.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        data_d   = data_q;
        sclk_d   = sclk_q;
        frst_n_d = frst_n_q;
        case (state_q)
            ST_IDLE: begin
                phase_d  = 1'b0;
                data_d   = 1'b0;
                sclk_d   = 1'b0;
                frst_n_d = 1'b1;
                if (bus.i_valid && bus.en) begin
                    sr_d     = bus.i_data;
                    bit_d    = BW'(DATA_W - 1);
                    frst_n_d = 1'b0;
                    state_d  = ST_FRST;
                end
            end
            ST_FRST: begin
                frst_n_d = 1'b0;
                sclk_d   = 1'b0;
                data_d   = 1'b0;
                if (tick) begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        frst_n_d = 1'b1;
                        data_d   = sr_q[DATA_W-1];
                        state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        sr_d   = sr_q << 1;
                        bit_d  = bit_q - BW'(1);
                        // Next MSB is presented on the falling edge, never while the clock is high.
                        data_d = (bit_q == '0) ? 1'b0 : sr_q[DATA_W-2];
                        if (bit_q == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            frst_n_q <= 1'b0;
        end else if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            frst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
            sclk_q   <= sclk_d;
            frst_n_q <= frst_n_d;
        end
    end

    assign bus.SGPIO_FPGA_DBG_CPU0_DATA = data_q;
    assign bus.SGPIO_FPGA_DBG_RST_N     = frst_n_q;
    assign bus.SGPIO_FPGA_DBG_CLK_100k  = sclk_q;

endmodule

// File: tb/tb_sgpio_shifter.sv
// Bench for sgpio_shifter: a receiver model collects frames and compares them to a queue of sent bytes.
module tb_sgpio_shifter;

    localparam int unsigned HD = 250;

    logic aclk = 1'b0;
    logic aresetn;
    logic reset;

    sgpio_shifter_if bus ();

    sgpio_shifter dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .reset   (reset),
        .bus     (bus)
    );

    always #10 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic        abort_f   = 1'b0;
    int unsigned rise_cnt  = 0;
    int unsigned rstlo_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: shift on CLK rising edge, cleared by RST_N low; also checks phase timing.
    logic        p_clk  = 1'b0;
    logic        p_data = 1'b0;
    logic        hi_chg = 1'b0;
    int unsigned hi_len = 0;
    int unsigned lo_len = 0;
    int unsigned nbits  = 0;
    logic [7:0]  rx     = 8'h00;

    always @(negedge aclk) begin
        logic c, d, r;
        c = bus.SGPIO_FPGA_DBG_CLK_100k;
        d = bus.SGPIO_FPGA_DBG_CPU0_DATA;
        r = bus.SGPIO_FPGA_DBG_RST_N;
        if (!r) begin
            rstlo_cnt++;
            nbits  = 0;
            lo_len = 0;
        end
        if (c && !p_clk) begin
            rise_cnt++;
            if (!abort_f) check_eq("lo_phase", 32'(lo_len), 32'(HD));
            rx     = {rx[6:0], d};
            nbits++;
            hi_len = 1;
            hi_chg = 1'b0;
            lo_len = 0;
            if (nbits == 8) begin
                nbits = 0;
                check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("frame_data", 32'(rx), 32'(exp_q.pop_front()));
            end
        end else if (c) begin
            hi_len++;
            if (d != p_data) hi_chg = 1'b1;
        end else if (p_clk) begin
            if (!abort_f) begin
                check_eq("hi_phase", 32'(hi_len), 32'(HD));
                check_eq("hi_data_stable", 32'(hi_chg), 32'd0);
            end
            lo_len = r ? 1 : 0;
        end else if (r) begin
            lo_len++;
        end
        p_clk  = c;
        p_data = d;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Packed as {DATA, RST_N, CLK}.
    task automatic check_out(input string tag, input logic [2:0] exp);
        check_eq(tag, 32'({bus.SGPIO_FPGA_DBG_CPU0_DATA, bus.SGPIO_FPGA_DBG_RST_N,
                           bus.SGPIO_FPGA_DBG_CLK_100k}), 32'(exp));
    endtask

    task automatic send(input logic [7:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned budget, input string tag);
        int unsigned i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        repeat (300) tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r0, l0;
        aresetn     = 1'b1;
        reset       = 1'b0;
        bus.en      = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;

        #5 aresetn = 1'b0;
        #1 check_out("async_reset", 3'b000);
        repeat (3) tick();
        check_out("reset_hold", 3'b000);
        aresetn = 1'b1;
        tick();
        check_out("reset_release", 3'b010);

        // 0xA5 with cycle-exact frame timing
        send(8'hA5, 1'b1);
        check_out("frst_start", 3'b000);
        for (int k = 1; k <= 4500; k++) begin
            tick();
            if (k == 499)  check_out("frst_end", 3'b000);
            if (k == 500)  check_out("shift_start", 3'b110);
            if (k == 749)  check_out("clk_first_low", 3'b110);
            if (k == 750)  check_out("clk_first_rise", 3'b111);
            if (k == 4499) check_out("last_high", 3'b111);
            if (k == 4500) check_out("back_idle", 3'b010);
        end
        check_eq("a5_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) tick();

        // Strobe during a frame is dropped; a later one is sent
        send(8'hA5, 1'b1);
        repeat (99) tick();
        send(8'h3C, 1'b0);
        repeat (8000 - 101) tick();
        check_eq("t2_a5_done", 32'(exp_q.size()), 32'd0);
        send(8'h3C, 1'b1);
        drain(5000, "t2_drain");

        // en=0 drops the strobe; en dropped mid-frame does not abort
        bus.en = 1'b0;
        r0 = rise_cnt;
        l0 = rstlo_cnt;
        send(8'hFF, 1'b0);
        repeat (5000) tick();
        check_eq("en0_no_clk", 32'(rise_cnt - r0), 32'd0);
        check_eq("en0_no_rst", 32'(rstlo_cnt - l0), 32'd0);
        check_out("en0_idle", 3'b010);
        bus.en = 1'b1;
        send(8'hFF, 1'b1);
        check_out("ff_start", 3'b000);
        repeat (100) tick();
        bus.en = 1'b0;
        drain(5000, "ff_drain");
        bus.en = 1'b1;

        // Async reset during bit 3 of 0x81
        send(8'h81, 1'b1);
        repeat (2799) tick();
        check_out("pre_async", 3'b011);
        abort_f = 1'b1;
        aresetn = 1'b0;
        #1 check_out("abort_async", 3'b000);
        void'(exp_q.pop_front());
        repeat (3) tick();
        check_out("async_hold", 3'b000);
        aresetn = 1'b1;
        tick();
        check_out("async_recover", 3'b010);
        abort_f = 1'b0;
        send(8'h81, 1'b1);
        drain(5000, "t4_drain");

        // Soft reset for one cycle during bit 3 of 0x81
        send(8'h81, 1'b1);
        repeat (2799) tick();
        check_out("pre_soft", 3'b011);
        abort_f = 1'b1;
        reset   = 1'b1;
        tick();
        check_out("soft_reset", 3'b000);
        reset = 1'b0;
        void'(exp_q.pop_front());
        tick();
        check_out("soft_recover", 3'b010);
        abort_f = 1'b0;
        send(8'h3C, 1'b1);
        drain(5000, "t5_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
